// File: rtl/xulie_pkg.sv
// xulie_pkg: shared state type, default widths and 50 MHz timing constants for the pattern sequencer.
package xulie_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PAT_W_DEF = 16;
  localparam int LEN_W_DEF = 5;
  localparam int DIV_W_DEF = 16;
  localparam int REP_W_DEF = 8;
  localparam int CLK_HZ = 50_000_000;
  localparam int CYC_10US = CLK_HZ / 100_000;
  localparam int CYC_1US = CLK_HZ / 1_000_000;
endpackage

// File: rtl/xulie_tick_div.sv
// xulie_tick_div: bit-period divider, pulses tick when the count reaches bit_div, then wraps.
module xulie_tick_div import xulie_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] bit_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == bit_div;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/xulie_seq_ctrl.sv
// xulie_seq_ctrl: programmable MSB-first serial pattern sequencer with start/stop/busy/done handshake.
// Define XULIE_LOOP_EN to make cfg_repeat==0 loop until stop or rst.
module xulie_seq_ctrl import xulie_pkg::*; #(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [DIV_W-1:0] cfg_bit_div,
  input  logic [REP_W-1:0] cfg_repeat,
  input  logic             start,
  input  logic             stop,
  output logic             sig_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_idx
);
  state_t state, state_nx;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r, idx_nx, top_idx;
  logic [DIV_W-1:0] div_r;
  logic [REP_W-1:0] rep_r, pass_r, pass_nx;
  logic sig_nx, busy_nx, done_nx, div_clr, tick, last_pass;
  assign top_idx = len_r - 1'b1;
`ifdef XULIE_LOOP_EN
  assign last_pass = rep_r != '0 && pass_r == rep_r - 1'b1;
`else
  assign last_pass = pass_r + 1'b1 >= rep_r;
`endif
  xulie_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk(clk), .rst(rst), .clr(div_clr), .en(state == RUN), .bit_div(div_r), .tick(tick)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r <= '0;
      len_r <= '0;
      div_r <= '0;
      rep_r <= '0;
    end else if (cfg_we && state == IDLE) begin
      pat_r <= cfg_pattern;
      len_r <= (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
      div_r <= cfg_bit_div;
      rep_r <= cfg_repeat;
    end
  end
  always_comb begin
    state_nx = state;
    sig_nx = sig_out;
    busy_nx = busy;
    done_nx = 1'b0;
    idx_nx = bit_idx;
    pass_nx = pass_r;
    div_clr = 1'b0;
    if (state == IDLE) begin
      if (start && !stop && len_r != '0) begin
        state_nx = RUN;
        busy_nx = 1'b1;
        idx_nx = top_idx;
        sig_nx = 1'(pat_r >> top_idx);
        pass_nx = '0;
        div_clr = 1'b1;
      end
    end else if (stop || (tick && bit_idx == '0 && last_pass)) begin
      state_nx = IDLE;
      busy_nx = 1'b0;
      sig_nx = 1'b0;
      idx_nx = '0;
      done_nx = !stop;
      div_clr = 1'b1;
    end else if (tick) begin
      idx_nx = (bit_idx == '0) ? top_idx : bit_idx - 1'b1;
      sig_nx = 1'(pat_r >> idx_nx);
      pass_nx = (bit_idx == '0) ? pass_r + 1'b1 : pass_r;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sig_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      bit_idx <= '0;
      pass_r <= '0;
    end else begin
      state <= state_nx;
      sig_out <= sig_nx;
      busy <= busy_nx;
      done <= done_nx;
      bit_idx <= idx_nx;
      pass_r <= pass_nx;
    end
  end
endmodule
